// File: rtl/mem_load_store_unit_pkg.sv
// mem_lsu_pkg: access-size encodings, RMW state enum and the big-endian lane mask helper.
package mem_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {IDLE, RMW_WR} state_e;

    // Byte offset 0 is the most significant lane.
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        lane_mask = size == SIZE_BYTE ? 32'hFF00_0000 >> {off, 3'b000} :
                    size == SIZE_HALF ? 32'hFFFF_0000 >> {off[1], 4'b0000} : 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/mem_load_store_unit_if.sv
// mem_load_store_unit_if: pipeline-side request/response and memory-side port bundle of the load/store unit.
interface mem_load_store_unit_if #(parameter int DATA_W = 32);
    logic [31:0]       Addr_MEM;
    logic [DATA_W-1:0] Store_Data_MEM;
    logic              MemRead_MEM;
    logic              MemWrite_MEM;
    logic [1:0]        Mem_Size_MEM;
    logic              Mem_Unsigned;
    logic              Flush_MEM;
    logic [DATA_W-1:0] Load_Data_MEM;
    logic              Stall_MEM;
    logic              Addr_Error;
    logic [31:0]       Bad_VAddr;
    logic [31:0]       Mem_Addr;
    logic [DATA_W-1:0] Mem_Write_Data;
    logic              Mem_Read;
    logic              Mem_Write;
    logic [DATA_W-1:0] Mem_Read_Data;

    modport master (
        output Addr_MEM, Store_Data_MEM, MemRead_MEM, MemWrite_MEM, Mem_Size_MEM, Mem_Unsigned, Flush_MEM,
               Mem_Read_Data,
        input  Load_Data_MEM, Stall_MEM, Addr_Error, Bad_VAddr, Mem_Addr, Mem_Write_Data, Mem_Read, Mem_Write
    );

    modport slave (
        input  Addr_MEM, Store_Data_MEM, MemRead_MEM, MemWrite_MEM, Mem_Size_MEM, Mem_Unsigned, Flush_MEM,
               Mem_Read_Data,
        output Load_Data_MEM, Stall_MEM, Addr_Error, Bad_VAddr, Mem_Addr, Mem_Write_Data, Mem_Read, Mem_Write
    );
endinterface

// File: rtl/mem_load_store_unit_load_align.sv
// lsu_load_align: picks the addressed big-endian lane of a memory word and sign/zero-extends it.
module lsu_load_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // ~off is 3-off, i.e. the lane count below the addressed byte.
    assign byte_v = 8'(word_i >> {~off_i, 3'b000});
    assign half_v = 16'(word_i >> {~off_i[1], 4'b0000});

    always_comb begin
        data_o = size_i == SIZE_BYTE ? {{24{byte_v[7] & ~unsigned_i}}, byte_v} :
                 size_i == SIZE_HALF ? {{16{half_v[15] & ~unsigned_i}}, half_v} : word_i;
    end
endmodule

// File: rtl/mem_load_store_unit.sv
// mem_load_store_unit: MEM-stage load/store unit; checks alignment/range, extends loads,
// and turns SB/SH into a stalled read-modify-write because the memory has no byte enables.
module mem_load_store_unit
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 512
) (
    input logic                Clk,
    input logic                Rst_n,
    mem_load_store_unit_if.slave bus
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       bad_vaddr_q, bad_vaddr_d;
    logic [31:0]       word_idx;
    logic [31:0]       mask;
    logic [DATA_W-1:0] store_rep;
    logic [DATA_W-1:0] aligned;
    logic              idle, valid, is_word, misaligned, err;
    logic              is_store, is_load, is_partial;

    assign word_idx   = {2'b00, bus.Addr_MEM[31:2]};
    assign idle       = state_q == IDLE;
    // While the write half of an RMW is in flight the held inputs are ignored.
    assign valid      = idle & (bus.MemRead_MEM | bus.MemWrite_MEM) & ~bus.Flush_MEM;
    assign is_word    = bus.Mem_Size_MEM[1];
    assign misaligned = is_word ? |bus.Addr_MEM[1:0] : (bus.Mem_Size_MEM == SIZE_HALF) & bus.Addr_MEM[0];
    assign err        = valid & (misaligned | (word_idx >= 32'(MEM_WORDS)));
    assign is_store   = valid & ~err & bus.MemWrite_MEM;
    assign is_load    = valid & ~err & ~bus.MemWrite_MEM;
    assign is_partial = is_store & ~is_word;

    assign mask      = lane_mask(bus.Mem_Size_MEM, bus.Addr_MEM[1:0]);
    assign store_rep = bus.Mem_Size_MEM == SIZE_BYTE ? {4{bus.Store_Data_MEM[7:0]}} : {2{bus.Store_Data_MEM[15:0]}};

    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .word_i     (bus.Mem_Read_Data),
        .off_i      (bus.Addr_MEM[1:0]),
        .size_i     (bus.Mem_Size_MEM),
        .unsigned_i (bus.Mem_Unsigned),
        .data_o     (aligned)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            merge_q     <= '0;
            addr_q      <= '0;
            bad_vaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    always_comb begin
        state_d     = idle ? IDLE : IDLE;
        merge_d     = merge_q;
        addr_d      = addr_q;
        bad_vaddr_d = err ? bus.Addr_MEM : bad_vaddr_q;
        if (is_partial) begin
            state_d = RMW_WR;
            merge_d = (bus.Mem_Read_Data & ~mask) | (store_rep & mask);
            addr_d  = word_idx;
        end
    end

    // Strobes are gated by Rst_n so nothing reaches memory while reset is held.
    always_comb begin
        bus.Mem_Addr       = idle ? word_idx : addr_q;
        bus.Mem_Write_Data = idle ? bus.Store_Data_MEM : merge_q;
        bus.Mem_Read       = Rst_n & (is_load | is_partial);
        bus.Mem_Write      = Rst_n & (~idle | (is_store & is_word));
        bus.Stall_MEM      = Rst_n & is_partial;
        bus.Addr_Error     = Rst_n & err;
        bus.Load_Data_MEM  = (Rst_n & is_load) ? aligned : '0;
        bus.Bad_VAddr      = bad_vaddr_q;
    end
endmodule

// File: tb/tb_mem_load_store_unit.sv
// tb_mem_load_store_unit: directed stimulus against a byte-level reference model of the MEM stage and memory.
module tb_mem_load_store_unit;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic preload = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    mem_load_store_unit_if #(.DATA_W(32)) bus ();

    mem_load_store_unit #(.DATA_W(32), .MEM_WORDS(512)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem_arr [512];
    logic [31:0] ref_mem [512];

    assign bus.Mem_Read_Data = (bus.Mem_Addr == 0 || bus.Mem_Addr >= 512) ? 32'h0 : mem_arr[bus.Mem_Addr[8:0]];

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem_arr[i] <= 32'h0;
            mem_arr[4] <= 32'h1280_3456;
            mem_arr[8] <= 32'h1122_3344;
            mem_arr[9] <= 32'h5566_7788;
        end else if (bus.Mem_Write && bus.Mem_Addr < 512) begin
            mem_arr[bus.Mem_Addr[8:0]] <= bus.Mem_Write_Data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending write record, last bad address, byte-wise memory view.
    logic        pend = 1'b0;
    logic [31:0] pend_idx = 0, pend_val = 0, m_bad = 0;
    logic        n_pend = 1'b0, n_wr = 1'b0;
    logic [31:0] n_pidx = 0, n_pval = 0, n_idx = 0, n_data = 0, n_bad = 0;
    logic [31:0] m_a, m_d, m_w, val;
    int unsigned nb, idx, off;
    int unsigned b [4];
    logic        v, fault, e_rd, e_wr, e_stall;
    logic [31:0] e_load;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            chk("rst_rd", bus.Mem_Read, 0);
            chk("rst_wr", bus.Mem_Write, 0);
            chk("rst_stall", bus.Stall_MEM, 0);
            chk("rst_err", bus.Addr_Error, 0);
            chk("rst_load", bus.Load_Data_MEM, 0);
            chk("rst_bad", bus.Bad_VAddr, 0);
            n_pend = 0; n_wr = 0; n_bad = 0;
        end else if (pend) begin
            chk("rmw_wr", bus.Mem_Write, 1);
            chk("rmw_rd", bus.Mem_Read, 0);
            chk("rmw_stall", bus.Stall_MEM, 0);
            chk("rmw_err", bus.Addr_Error, 0);
            chk("rmw_addr", bus.Mem_Addr, pend_idx);
            chk("rmw_data", bus.Mem_Write_Data, pend_val);
            chk("rmw_bad", bus.Bad_VAddr, m_bad);
            n_wr = 1; n_idx = pend_idx; n_data = pend_val; n_pend = 0; n_bad = m_bad;
        end else begin
            m_a = bus.Addr_MEM; m_d = bus.Store_Data_MEM;
            v = (bus.MemRead_MEM || bus.MemWrite_MEM) && !bus.Flush_MEM;
            nb = bus.Mem_Size_MEM == 0 ? 1 : bus.Mem_Size_MEM == 1 ? 2 : 4;
            idx = m_a / 4; off = m_a % 4;
            fault = v && ((m_a % nb) != 0 || idx >= 512);
            m_w = (idx == 0 || idx >= 512) ? 32'h0 : ref_mem[idx];
            for (int i = 0; i < 4; i++) b[i] = (m_w >> (24 - 8 * i)) & 255;
            e_rd = 0; e_wr = 0; e_stall = 0; e_load = 0; n_wr = 0; n_pend = 0;
            n_bad = fault ? m_a : m_bad;
            if (v && !fault) begin
                if (bus.MemWrite_MEM) begin
                    if (nb == 4) begin
                        e_wr = 1; n_wr = 1; n_idx = idx; n_data = m_d;
                    end else begin
                        e_rd = 1; e_stall = 1;
                        if (nb == 1) b[off] = m_d & 255;
                        else begin
                            b[off] = (m_d >> 8) & 255;
                            b[off + 1] = m_d & 255;
                        end
                        n_pend = 1; n_pidx = idx;
                        n_pval = (b[0] << 24) | (b[1] << 16) | (b[2] << 8) | b[3];
                    end
                end else begin
                    e_rd = 1;
                    val = nb == 1 ? b[off] : nb == 2 ? b[off] * 256 + b[off + 1] : m_w;
                    if (!bus.Mem_Unsigned && nb == 1 && val >= 128) val = val - 256;
                    if (!bus.Mem_Unsigned && nb == 2 && val >= 32768) val = val - 65536;
                    e_load = val;
                end
            end
            chk("rd", bus.Mem_Read, e_rd);
            chk("wr", bus.Mem_Write, e_wr);
            chk("stall", bus.Stall_MEM, e_stall);
            chk("err", bus.Addr_Error, fault);
            chk("load", bus.Load_Data_MEM, e_load);
            chk("bad", bus.Bad_VAddr, m_bad);
            if (e_rd || e_wr) chk("addr", bus.Mem_Addr, idx);
            if (e_wr) chk("wdata", bus.Mem_Write_Data, m_d);
        end
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend <= 1'b0;
            m_bad <= 32'h0;
        end else begin
            pend <= n_pend;
            pend_idx <= n_pidx;
            pend_val <= n_pval;
            m_bad <= n_bad;
        end
    end

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ref_mem[i] <= 32'h0;
            ref_mem[4] <= 32'h1280_3456;
            ref_mem[8] <= 32'h1122_3344;
            ref_mem[9] <= 32'h5566_7788;
        end else if (Rst_n && n_wr && n_idx < 512) begin
            ref_mem[n_idx[8:0]] <= n_data;
        end
    end

    task automatic set_in(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic fl, input logic [31:0] a, input logic [31:0] d);
        bus.MemRead_MEM = rd; bus.MemWrite_MEM = wr; bus.Mem_Size_MEM = sz;
        bus.Mem_Unsigned = uns; bus.Flush_MEM = fl; bus.Addr_MEM = a; bus.Store_Data_MEM = d;
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    int  cyc;
    logic st;

    initial begin
        set_in(1, 0, 2'b10, 0, 0, 32'h10, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("lit_rst_read", bus.Mem_Read, 0);
        chk("lit_rst_load", bus.Load_Data_MEM, 0);
        @(posedge Clk); #1;
        preload = 0; Rst_n = 1;
        set_in(1, 0, 2'b00, 0, 0, 32'h11, 0);
        @(negedge Clk); chk("lit_lb", bus.Load_Data_MEM, 32'hFFFF_FF80); nxt();
        set_in(1, 0, 2'b00, 1, 0, 32'h11, 0);
        @(negedge Clk); chk("lit_lbu", bus.Load_Data_MEM, 32'h0000_0080); nxt();
        set_in(1, 0, 2'b01, 0, 0, 32'h12, 0); nxt();
        set_in(1, 0, 2'b01, 1, 0, 32'h10, 0); nxt();
        set_in(0, 1, 2'b01, 0, 0, 32'h22, 32'h0000_BEEF);
        @(negedge Clk); chk("lit_sh_stall", bus.Stall_MEM, 1); nxt();
        @(negedge Clk);
        chk("lit_sh_stall_wr", bus.Stall_MEM, 0);
        chk("lit_sh_wdata", bus.Mem_Write_Data, 32'h1122_BEEF);
        chk("lit_sh_addr", bus.Mem_Addr, 8);
        nxt();
        set_in(1, 0, 2'b01, 0, 0, 32'h22, 0);
        @(negedge Clk); chk("lit_lh_neg", bus.Load_Data_MEM, 32'hFFFF_BEEF); nxt();
        set_in(1, 0, 2'b10, 0, 0, 32'h20, 0);
        @(negedge Clk); chk("lit_lw_merged", bus.Load_Data_MEM, 32'h1122_BEEF); nxt();
        set_in(1, 0, 2'b10, 0, 0, 32'h6, 0);
        @(negedge Clk); chk("lit_lw_err", bus.Addr_Error, 1); chk("lit_lw_err_rd", bus.Mem_Read, 0); nxt();
        set_in(0, 1, 2'b10, 0, 0, 32'h800, 32'h1234_5678);
        @(negedge Clk);
        chk("lit_bad_6", bus.Bad_VAddr, 32'h6);
        chk("lit_sw_range_err", bus.Addr_Error, 1);
        chk("lit_sw_range_wr", bus.Mem_Write, 0);
        nxt();
        set_in(1, 0, 2'b01, 0, 0, 32'h13, 0);
        @(negedge Clk); chk("lit_bad_800", bus.Bad_VAddr, 32'h800); nxt();
        set_in(0, 1, 2'b00, 0, 1, 32'h24, 32'hCC);
        @(negedge Clk); chk("lit_flush_rd", bus.Mem_Read, 0); chk("lit_flush_stall", bus.Stall_MEM, 0); nxt();
        set_in(0, 1, 2'b00, 0, 0, 32'h24, 32'hCC); nxt();
        bus.Flush_MEM = 1;
        @(negedge Clk); chk("lit_rmw_flush_wr", bus.Mem_Write, 1); chk("lit_rmw_flush_data", bus.Mem_Write_Data, 32'hCC66_7788); nxt();
        set_in(1, 0, 2'b10, 0, 0, 32'h24, 0); nxt();
        cyc = 0;
        set_in(0, 1, 2'b00, 0, 0, 32'h10, 32'hAA);
        do begin @(negedge Clk); st = bus.Stall_MEM; cyc++; nxt(); end while (st && cyc < 10);
        set_in(0, 1, 2'b00, 0, 0, 32'h11, 32'h1BB);
        do begin @(negedge Clk); st = bus.Stall_MEM; cyc++; nxt(); end while (st && cyc < 10);
        chk("lit_b2b_cycles", cyc, 4);
        set_in(1, 0, 2'b10, 0, 0, 32'h10, 0);
        @(negedge Clk); chk("lit_b2b_word", bus.Load_Data_MEM, 32'hAABB_3456); nxt();
        set_in(1, 1, 2'b10, 0, 0, 32'h34, 32'h0102_0304);
        @(negedge Clk); chk("lit_both_wr", bus.Mem_Write, 1); chk("lit_both_rd", bus.Mem_Read, 0); nxt();
        set_in(1, 0, 2'b11, 0, 0, 32'h34, 0);
        @(negedge Clk); chk("lit_rsvd_word", bus.Load_Data_MEM, 32'h0102_0304); nxt();
        set_in(0, 1, 2'b00, 0, 0, 32'h2, 32'h77); nxt(); nxt();
        set_in(1, 0, 2'b10, 0, 0, 32'h0, 0); nxt();
        set_in(0, 1, 2'b00, 0, 0, 32'h20, 32'h99);
        @(negedge Clk); chk("lit_rst_rmw_stall", bus.Stall_MEM, 1);
        @(posedge Clk); #1;
        Rst_n = 0;
        @(negedge Clk); chk("lit_rst_rmw_wr", bus.Mem_Write, 0);
        @(posedge Clk); #1;
        Rst_n = 1;
        chk("lit_rst_rmw_mem", mem_arr[8], 32'h1122_BEEF);
        set_in(1, 0, 2'b10, 0, 0, 32'h20, 0);
        @(negedge Clk); chk("lit_rst_rmw_idle_rd", bus.Mem_Read, 1); chk("lit_rst_rmw_load", bus.Load_Data_MEM, 32'h1122_BEEF); nxt();
        set_in(0, 0, 2'b10, 0, 0, 0, 0);
        @(negedge Clk);
        chk("lit_final_word4", mem_arr[4], 32'hAABB_3456);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
